// File: rtl/mult_seq_ctrl_pkg.sv
// rtl/mult_seq_ctrl_pkg.sv - shared state encoding and default width for the multiplier sequencer
package mult_seq_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl_step.sv
// rtl/mult_seq_ctrl_step.sv - one combinational add/shift iteration of the multiplier
module mult_seq_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;

  // Sum is one bit wider so the carry out of the upper half shifts back in.
  always_comb begin
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
    if (acc_in[0]) begin
      sum = sum + {1'b0, mcand};
    end
    acc_out = {sum, acc_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequencer for the 32x32->64 shift-and-add multiplier (MULT/MULTU)
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        count;
  logic                 neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  // 0x80000000 negates to itself; read as unsigned that is the correct magnitude.
  always_comb begin
    a_mag = (signed_op && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
    b_mag = (signed_op && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;
  end

  mult_seq_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc),
    .mcand   (mcand),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      neg     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= {{WIDTH{1'b0}}, b_mag};
            mcand <= a_mag;
            neg   <= signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            product <= neg ? (~acc_next + 1'b1) : acc_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed-vector bench for the multiplier sequencer
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int vectors = 0;
  int miscompares = 0;

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_op    (signed_op),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a request so it is sampled at the next rising edge, then drop start.
  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_op    = s;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges counted after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu_basic;
    int edges;
    do_start(1'b0, 32'h76543211, 32'h00000005);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: busy=%b, required 1", busy);
    end
    wait_done(edges);
    vectors++;
    if (edges != 32) begin
      miscompares++;
      $display("FAIL multu_latency: edges=%0d, required 32", edges);
    end
    vectors++;
    if (product !== 64'h000000024FA4FA55 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL multu_basic: product=%h busy=%b, required 000000024fa4fa55 0", product, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || product !== 64'h000000024FA4FA55) begin
      miscompares++;
      $display("FAIL done_pulse_width: done=%b product=%h, required 0 000000024fa4fa55", done, product);
    end
  endtask

  task automatic test_multu_all_ones;
    int edges;
    do_start(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(edges);
    vectors++;
    if (edges != 32 || product !== 64'hFFFFFFFE00000001) begin
      miscompares++;
      $display("FAIL multu_all_ones: edges=%0d product=%h, required 32 fffffffe00000001", edges, product);
    end
  endtask

  task automatic test_mult_signed;
    int edges;
    do_start(1'b1, 32'hFFFFFFFD, 32'h00000007);
    wait_done(edges);
    vectors++;
    if (edges != 32 || product !== 64'hFFFFFFFFFFFFFFEB) begin
      miscompares++;
      $display("FAIL mult_neg3x7: edges=%0d product=%h, required 32 ffffffffffffffeb", edges, product);
    end
    do_start(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(edges);
    vectors++;
    if (edges != 32 || product !== 64'h0000000080000000) begin
      miscompares++;
      $display("FAIL mult_most_negative: edges=%0d product=%h, required 32 0000000080000000", edges, product);
    end
    do_start(1'b1, 32'h00000000, 32'h12345678);
    wait_done(edges);
    vectors++;
    if (edges != 32 || product !== 64'd0) begin
      miscompares++;
      $display("FAIL mult_zero: edges=%0d product=%h, required 32 0", edges, product);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    do_start(1'b0, 32'h00000010, 32'h00000010);
    wait_done(edges);
    vectors++;
    if (edges != 32 || product !== 64'h100) begin
      miscompares++;
      $display("FAIL b2b_first: edges=%0d product=%h, required 32 100", edges, product);
    end
    // Request lands during the DONE cycle.
    signed_op = 1'b0;
    multiplicand = 32'd2;
    multiplier = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 64'h100) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b product=%h, required 1 0 100", busy, done, product);
    end
    wait_done(edges);
    vectors++;
    if (edges != 32 || product !== 64'd6) begin
      miscompares++;
      $display("FAIL b2b_second: edges=%0d product=%h, required 32 6", edges, product);
    end
  endtask

  task automatic test_start_ignored_in_run;
    int edges;
    edges = -1;
    do_start(1'b0, 32'h76543211, 32'h00000005);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = i;
        break;
      end
      if (i == 5 || i == 20) begin
        signed_op = 1'b1;
        multiplicand = 32'hDEADBEEF;
        multiplier = 32'h0000FFFF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    vectors++;
    if (edges != 32 || product !== 64'h000000024FA4FA55) begin
      miscompares++;
      $display("FAIL start_in_run: edges=%0d product=%h, required 32 000000024fa4fa55", edges, product);
    end
  endtask

  task automatic test_reset_mid_op;
    int bad;
    bad = 0;
    do_start(1'b0, 32'h00001234, 32'h00005678);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: busy=%b done=%b product=%h, required 0 0 0", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL after_reset_idle: %0d cycles with busy/done high, required 0", bad);
    end
    do_start(1'b0, 32'd7, 32'd9);
    wait_done(bad);
    vectors++;
    if (bad != 32 || product !== 64'd63) begin
      miscompares++;
      $display("FAIL restart_after_reset: edges=%0d product=%h, required 32 3f", bad, product);
    end
  endtask

  initial begin
    test_reset;
    test_multu_basic;
    test_multu_all_ones;
    test_mult_signed;
    test_back_to_back;
    test_start_ignored_in_run;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
